// File: rtl/seg_display_scan_if.sv
// Signal bundle between the fare-meter counters and the seven-segment scan driver.
// Debug taps expose the conversion FSM state and the committed BCD to checkers.
interface seg_display_scan_if;
  // No handshake: data_in/point are level inputs sampled only in the conversion
  // FSM's IDLE cycle; sel/seg are registered outputs that change only on a scan tick.
  logic [15:0] data_in;
  logic [3:0]  point;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_bcd;

  modport master (output data_in, point, input sel, seg, dbg_state, dbg_bcd);
  modport slave  (input data_in, point, output sel, seg, dbg_state, dbg_bcd);
endinterface

// File: rtl/seg_display_scan.sv
// Four-digit common-anode display driver: sequential shift-add-3 binary-to-BCD
// conversion feeding a time-multiplexed digit scan with leading-zero blanking.
module seg_display_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  seg_display_scan_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ovr_pend_q, ovr_pend_d;
  logic [3:0]        pt_pend_q, pt_pend_d;
  logic [15:0]       disp_bcd_q, disp_bcd_d;
  logic              disp_ovr_q, disp_ovr_d;
  logic [3:0]        disp_pt_q, disp_pt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic [15:0]       adj_bcd;
  logic              tick;
  logic [3:0]        nib;
  logic [15:0]       upper;
  logic [3:0]        pt_hi;
  logic [7:0]        digit_seg;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] enc7(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign adj_bcd = add3(bcd_q);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovr_pend_d = ovr_pend_q;
    pt_pend_d  = pt_pend_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovr_d = disp_ovr_q;
    disp_pt_d  = disp_pt_q;
    case (state_q)
      ST_IDLE: begin
        bin_d      = bus.data_in;
        bcd_d      = 16'd0;
        cnt_d      = 4'd0;
        ovr_pend_d = (bus.data_in > 16'd9999);
        pt_pend_d  = bus.point;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj_bcd[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_bcd_d = bcd_q;
        disp_ovr_d = ovr_pend_q;
        disp_pt_d  = pt_pend_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The encoder looks at next-state display registers so a tick coinciding
  // with a commit already shows the new value.
  always_comb begin
    tick  = (div_q == DIV_MAX);
    div_d = tick ? '0 : div_q + DIV_ONE;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    nib   = disp_bcd_d[{idx_d, 2'b00} +: 4];
    upper = disp_bcd_d >> {idx_d, 2'b00};
    pt_hi = disp_pt_d >> idx_d;
    digit_seg = enc7(nib);
    if (disp_pt_d[idx_d]) digit_seg[7] = 1'b0;
    if ((idx_d != 2'd0) && (upper == 16'd0) && (pt_hi == 4'd0)) digit_seg = 8'hFF;
    if (disp_ovr_d) digit_seg = 8'hBF;
    sel_d = sel_q;
    seg_d = seg_q;
    if (tick) begin
      sel_d = ~(4'b0001 << idx_d);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= 16'd0;
      bcd_q      <= 16'd0;
      cnt_q      <= 4'd0;
      ovr_pend_q <= 1'b0;
      pt_pend_q  <= 4'd0;
      disp_bcd_q <= 16'd0;
      disp_ovr_q <= 1'b0;
      disp_pt_q  <= 4'd0;
      div_q      <= '0;
      idx_q      <= 2'd3;
      sel_q      <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovr_pend_q <= ovr_pend_d;
      pt_pend_q  <= pt_pend_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovr_q <= disp_ovr_d;
      disp_pt_q  <= disp_pt_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.seg       = seg_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_bcd   = disp_bcd_q;

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Four-digit seven-segment display driver for the taxi-fare meter. It reads a binary display value (0–9999), such as the kilometre count or the fare, together with its decimal-point mask. It converts the value to BCD with a sequential shift-add-3 engine and time-multiplexes the four digits onto a common-anode display. It is the consumer of the counter outputs and drives the board LED pins directly.

## Interface
- CLK_DIV, 50000: `sys_clk` cycles per digit slot (1 kHz slot rate at 50 MHz); minimum 2.
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_reset  input  1  asynchronous, active-high reset.
- data_in  input  16  binary value to display; valid range 0–9999.
- point  input  4  decimal-point mask; bit i lights the dp of digit i (digit 0 = rightmost).
- sel  output  4  digit enables, active-low one-hot; bit i selects digit i.
- seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

## Operation
- **Conversion FSM, free-running, 18 cycles per pass:**
  - IDLE (1 cycle): capture data_in into the shift register and point into the pending-point register. Clear the BCD accumulator. Set the over-range flag if data_in > 9999. Go to SHIFT.
  - SHIFT (16 cycles): on each cycle, first add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. A 4-bit counter tracks the cycles. After the 16th shift, go to DONE.
  - DONE (1 cycle): commit the 16-bit BCD, the over-range flag and the pending point to the display registers atomically. Go to IDLE.
- data_in and point are sampled only in IDLE. Changes during SHIFT or DONE have no effect until the next pass.
- **Scan:**
  - The divider counts 0..CLK_DIV-1 and wraps. The terminal count is a one-cycle tick.
  - The digit index (2 bits) advances 0→1→2→3→0 on each tick.
  - sel and seg are registered and update only on a tick, using the display registers and the new index.
- **Digit encode** (active-low, dp bit set to 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Nibbles A–F must not occur; if one does, encode it as blank (FF).
  - If the display point bit i is set, clear seg[7] for digit i.
- **Leading-zero blanking:**
  - Digit i (i ≥ 1) outputs FF when its nibble and every higher nibble are zero and i is greater than the index of the highest set point bit.
  - Digit 0 is never blanked.
- **Over-range:** every digit outputs BF (segment g only). The dp is off regardless of point.

## Timing
- **Reset values:**
  - sel=4'b1111, seg=8'hFF.
  - FSM=IDLE, divider=0, index=3, so the first tick selects digit 0.
  - Display BCD=0, display point=0, over-range=0.
- Reset is asynchronous on assertion. Logic leaves reset on the first rising edge after deassertion.
- **First tick:** after reset release, the first tick comes CLK_DIV cycles later, with sel=1110 and seg=C0. The first conversion commits at cycle 18.
- **Latency:** a data_in value stable for at least 19 cycles is committed within 36 cycles. It appears on each digit at that digit's next slot.
- **Simultaneous commit and tick:** the tick uses the newly committed display registers.
- **Reset mid-conversion or mid-scan:** the partial conversion is discarded, outputs return to blank immediately, and the display registers clear.
- sel is always one-hot or all-ones. It never has two digits active.

## Test plan
- **Reset:** assert sys_reset mid-run with CLK_DIV=4 → sel=1111 and seg=FF asynchronously. After release, 4 cycles later → sel=1110, seg=C0.
- **data_in=1234, point=0010, CLK_DIV=4:** after 40 cycles, four consecutive ticks give (sel,seg) = (1110,99), (1101,30), (1011,A4), (0111,F9).
- **data_in=5, point=0010:** ticks give (1110,92), (1101,40), (1011,FF), (0111,FF). **data_in=0, point=0000:** (1110,C0), then FF on digits 1–3.
- **data_in=10000, point=0010:** all four digits show seg=BF. Then **data_in=9999, point=0000** → 90 on all four digits.
- **Mid-conversion change:** hold data_in=1234 through IDLE, then change it to 0007 on SHIFT cycle 5 → the commit holds BCD 0x1234. The next pass commits 0x0007 (digits 0=F8, 1–3=FF).
- **Conversion sweep:** drive 0..9999 exhaustively with CLK_DIV=2, one value per pass → the committed BCD matches the decimal value every time, and no nibble exceeds 9.
